fifo_wptr_full: RTL and testbench

Write-domain pointer and full-flag generator for the asynchronous FIFO. It is the transmitting end of the pointer crossing. It keeps the binary and Gray write pointers and drives the registered Gray pointer out to the read domain's 2-FF synchronizer. It takes the already-synchronized Gray read pointer back in and produces write enable/address, full, almost-full, fill level and a sticky overflow flag. It runs entirely in the write clock domain.

---
 rtl/fifo_wptr_full_if.sv | 25 ++
 rtl/fifo_wptr_full.sv | 73 +++++++
 tb/tb_fifo_wptr_full.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fifo_wptr_full_if.sv
// Write-side pointer bundle: producer request and read-pointer feedback in, RAM strobe and status out.
interface fifo_wptr_full_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  winc;
  logic [ADDR_WIDTH:0]   rq2_rptr_gray;
  logic                  clr_overflow;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wlevel;
  logic                  overflow;

  modport master (
    output winc, rq2_rptr_gray, clr_overflow,
    input  wen, waddr, wptr_gray, full, almost_full, wlevel, overflow
  );

  modport slave (
    input  winc, rq2_rptr_gray, clr_overflow,
    output wen, waddr, wptr_gray, full, almost_full, wlevel, overflow
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// Async-FIFO write pointer/full logic; wen is combinational, all status registered one edge after the write.
// Writes are refused while full (overflow latched); full releases one edge after the synced read pointer moves.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input logic             clk,
  input logic             rst,
  fifo_wptr_full_if.slave bus
);
  localparam int AW = ADDR_WIDTH;
  localparam int PW = ADDR_WIDTH + 1;

  logic [AW:0] wbin;
  logic [AW:0] wgray;
  logic [AW:0] wbin_next;
  logic [AW:0] wgray_next;
  logic [AW:0] rbin_s;
  logic [AW:0] level_next;
  logic [AW:0] full_match;
  logic [AW:0] level_q;
  logic        full_q;
  logic        afull_q;
  logic        ovf_q;
  logic        wen;

  assign wen        = bus.winc & ~full_q;
  assign wbin_next  = wbin + PW'(wen);
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
  assign full_match = {~bus.rq2_rptr_gray[AW:AW-1], bus.rq2_rptr_gray[AW-2:0]};

  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= AW; i++) begin
      rbin_s[i] = ^(bus.rq2_rptr_gray >> i);
    end
  end

  assign level_next = wbin_next - rbin_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin    <= '0;
      wgray   <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin    <= wbin_next;
      wgray   <= wgray_next;
      full_q  <= (wgray_next == full_match);
      afull_q <= (level_next >= PW'(AFULL_THRESH));
      level_q <= level_next;
      if (bus.winc && full_q) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_overflow) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // wptr_gray leaves straight from its flop so the crossing never sees a glitch.
  assign bus.wen         = wen;
  assign bus.waddr       = wbin[AW-1:0];
  assign bus.wptr_gray   = wgray;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.wlevel      = level_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: model-driven scoreboard for streams, hand-derived table for overrun/release.
module tb_fifo_wptr_full;
  typedef struct {
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] gray;
    logic       full;
    logic       afull;
    logic [4:0] level;
    logic       ovf;
    logic       afull16;
  } exp_t;

  typedef struct {
    logic       w;
    logic [4:0] rb;
    logic       c;
    exp_t       e;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  exp_t sb[$];
  vec_t tab [9];

  logic [4:0] m_wbin = '0;
  logic       m_full = 1'b0;
  logic       m_ovf  = 1'b0;

  fifo_wptr_full_if #(.ADDR_WIDTH(4)) b1 ();
  fifo_wptr_full_if #(.ADDR_WIDTH(4)) b2 ();

  assign b2.winc          = b1.winc;
  assign b2.rq2_rptr_gray = b1.rq2_rptr_gray;
  assign b2.clr_overflow  = b1.clr_overflow;

  fifo_wptr_full #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut   (.clk(clk), .rst(rst), .bus(b1));
  fifo_wptr_full #(.ADDR_WIDTH(4), .AFULL_THRESH(16)) dut16 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle; expected post-edge state comes from the model or from a table row.
  task automatic step(input logic w, input logic [4:0] rb, input logic c,
                      input logic use_tab, input vec_t tv);
    exp_t       e;
    exp_t       got;
    logic       wen_e;
    logic [4:0] lvl;
    b1.winc          = w;
    b1.rq2_rptr_gray = b2g(rb);
    b1.clr_overflow  = c;
    assert (5'(m_wbin - rb) <= 5'd16);
    wen_e = w & ~m_full;
    #1;
    chk("wen", b1.wen, use_tab ? tv.e.wen : wen_e);
    m_ovf  = (w && m_full) ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_wbin = m_wbin + 5'(wen_e);
    lvl    = 5'(m_wbin - rb);
    m_full = (lvl == 5'd16);
    e.wen     = wen_e;
    e.waddr   = m_wbin[3:0];
    e.gray    = b2g(m_wbin);
    e.full    = m_full;
    e.afull   = (lvl >= 5'd12);
    e.level   = lvl;
    e.ovf     = m_ovf;
    e.afull16 = (lvl >= 5'd16);
    if (use_tab) e = tv.e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      got = sb.pop_front();
      chk("waddr",     b1.waddr,        got.waddr);
      chk("wptr_gray", b1.wptr_gray,    got.gray);
      chk("full",      b1.full,         got.full);
      chk("afull",     b1.almost_full,  got.afull);
      chk("wlevel",    b1.wlevel,       got.level);
      chk("overflow",  b1.overflow,     got.ovf);
      chk("afull_t16", b2.almost_full,  got.afull16);
      chk("full_t16",  b2.full,         got.full);
    end
  endtask

  task automatic reset_check(input string tag);
    vec_t dummy;
    dummy = '{default: '0};
    b1.winc = 1'b1;
    rst     = 1'b1;
    #1;
    chk({tag, "_gray"},  b1.wptr_gray,   5'd0);
    chk({tag, "_waddr"}, b1.waddr,       4'd0);
    chk({tag, "_full"},  b1.full,        1'b0);
    chk({tag, "_afull"}, b1.almost_full, 1'b0);
    chk({tag, "_level"}, b1.wlevel,      5'd0);
    chk({tag, "_ovf"},   b1.overflow,    1'b0);
    chk({tag, "_wen"},   b1.wen,         1'b1);
    @(posedge clk);
    #1;
    chk({tag, "_held_gray"},  b1.wptr_gray, 5'd0);
    chk({tag, "_held_waddr"}, b1.waddr,     4'd0);
    rst    = 1'b0;
    m_wbin = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
  endtask

  initial begin
    logic [4:0] prev_gray;
    logic       saw_wrap;
    vec_t       none;
    none = '{default: '0};

    // Overrun, set-wins clear and release from full, derived by hand from a full FIFO at wbin=16.
    tab[0] = '{1'b1, 5'd0, 1'b0, '{1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1, 1'b1}};
    tab[1] = '{1'b1, 5'd0, 1'b0, '{1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1, 1'b1}};
    tab[2] = '{1'b1, 5'd0, 1'b0, '{1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1, 1'b1}};
    tab[3] = '{1'b1, 5'd0, 1'b1, '{1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1, 1'b1}};
    tab[4] = '{1'b0, 5'd0, 1'b1, '{1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0, 1'b1}};
    tab[5] = '{1'b0, 5'd1, 1'b0, '{1'b0, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd15, 1'b0, 1'b0}};
    tab[6] = '{1'b1, 5'd1, 1'b0, '{1'b1, 4'd1, 5'b11001, 1'b1, 1'b1, 5'd16, 1'b0, 1'b1}};
    tab[7] = '{1'b1, 5'd1, 1'b0, '{1'b0, 4'd1, 5'b11001, 1'b1, 1'b1, 5'd16, 1'b1, 1'b1}};
    tab[8] = '{1'b0, 5'd1, 1'b1, '{1'b0, 4'd1, 5'b11001, 1'b1, 1'b1, 5'd16, 1'b0, 1'b1}};

    b1.winc          = 1'b1;
    b1.rq2_rptr_gray = '0;
    b1.clr_overflow  = 1'b0;
    reset_check("por");

    for (int i = 0; i < 5; i++) step(1'b1, 5'd0, 1'b0, 1'b0, none);
    reset_check("mid");

    // Fill from empty: almost_full at the 12th edge, full at the 16th (both at 16 for the second instance).
    for (int i = 0; i < 16; i++) step(1'b1, 5'd0, 1'b0, 1'b0, none);

    for (int i = 0; i < 9; i++) step(tab[i].w, tab[i].rb, tab[i].c, 1'b1, tab[i]);

    reset_check("full");

    // Stream across the pointer wrap with the read pointer trailing two cycles behind.
    saw_wrap  = 1'b0;
    prev_gray = b1.wptr_gray;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, (k >= 2) ? 5'(k - 2) : 5'd0, 1'b0, 1'b0, none);
      chk("gray_one_bit", $countones(b1.wptr_gray ^ prev_gray), 1);
      if (prev_gray == 5'b10000 && b1.wptr_gray == 5'b00000) saw_wrap = 1'b1;
      prev_gray = b1.wptr_gray;
    end
    chk("gray_wrap_seen", saw_wrap, 1'b1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
